// File: rtl/cnt_run_ctrl.sv
// cnt_run_ctrl: run controller for an external mod-121 counter.
// Sequences clear / count / hold / done for a requested number of laps.
// It counts one lap on each tc-qualified wrap (tc=1 while enabled).
`timescale 1ns/1ps
module cnt_run_ctrl #(
  parameter int LAPW   = 8,
  parameter int TC_LAT = 0
) (
  input  logic            Clk,
  input  logic            MR,
  input  logic            start,
  input  logic            stop,
  input  logic            pause,
  input  logic [LAPW-1:0] laps,
  input  logic            tc,
  output logic            cnt_en,
  output logic            cnt_clr,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [LAPW-1:0] lap_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state;
  logic [LAPW-1:0] laps_r;
  logic            tc_q;
  logic            lap_hit;
  logic [LAPW-1:0] lap_next;

  // Only a zero-latency tc is supported. Any other setting masks laps,
  // so a misconfigured instance never completes a run.
  assign tc_q = (TC_LAT == 0) ? tc : 1'b0;

  // A lap is the wrap edge: tc seen while the counter is enabled in RUN.
  assign lap_hit  = (state == S_RUN) && cnt_en && tc_q;
  assign lap_next = lap_cnt + LAPW'(1);

  // Controller FSM. Every output is registered alongside the state.
  always_ff @(posedge Clk or negedge MR) begin
    if (!MR) begin
      state   <= S_IDLE;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      lap_cnt <= '0;
      laps_r  <= '0;
    end else begin
      // Pulse outputs default low; each state raises them as needed.
      cnt_clr <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt_en <= 1'b0;
          busy   <= 1'b0;
          if (stop) begin
            state <= S_IDLE;
          end else if (start) begin
            if (laps == '0) begin
              err <= 1'b1;
            end else begin
              state   <= S_CLEAR;
              laps_r  <= laps;
              lap_cnt <= '0;
              cnt_clr <= 1'b1;
              busy    <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          // The counter was cleared on entry; nothing more to clear here.
          if (stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state  <= S_RUN;
            cnt_en <= 1'b1;
          end
        end
        S_RUN: begin
          if (stop) begin
            state   <= S_IDLE;
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b1;
            busy    <= 1'b0;
          end else if (lap_hit) begin
            // A lap and a pause in the same cycle both take effect.
            lap_cnt <= lap_next;
            if (lap_next == laps_r) begin
              state  <= S_DONE;
              cnt_en <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else if (pause) begin
              state  <= S_HOLD;
              cnt_en <= 1'b0;
            end
          end else if (pause) begin
            state  <= S_HOLD;
            cnt_en <= 1'b0;
          end
        end
        S_HOLD: begin
          // tc is ignored here; the counter is frozen with cnt_en low.
          if (stop) begin
            state   <= S_IDLE;
            cnt_clr <= 1'b1;
            busy    <= 1'b0;
          end else if (!pause) begin
            state  <= S_RUN;
            cnt_en <= 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          cnt_en <= 1'b0;
          busy   <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          cnt_en <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_run_ctrl.sv
// tb_cnt_run_ctrl: directed plus randomized bench for cnt_run_ctrl.
// It includes a mod-121 counter model driven by cnt_en/cnt_clr.
// Expected behaviour is taken from run-level arithmetic:
// enabled cycles = 121 * laps, one clear, one done, and lap_cnt = wraps seen.
`timescale 1ns/1ps
module tb_cnt_run_ctrl;
  localparam int LAPW = 8;

  logic            Clk = 1'b0;
  logic            MR = 1'b0;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic            pause = 1'b0;
  logic [LAPW-1:0] laps = '0;
  logic            tc;
  logic            cnt_en, cnt_clr, busy, done, err;
  logic [LAPW-1:0] lap_cnt;

  int n_chk = 0;
  int n_err = 0;

  cnt_run_ctrl #(.LAPW(LAPW), .TC_LAT(0)) dut (
    .Clk(Clk), .MR(MR), .start(start), .stop(stop), .pause(pause),
    .laps(laps), .tc(tc), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .busy(busy), .done(done), .err(err), .lap_cnt(lap_cnt)
  );

  always #5 Clk = ~Clk;

  // mod-121 counter model fed by the controller outputs
  int cnt_m = 0;
  assign tc = (cnt_m == 120);
  always @(posedge Clk) begin
    if (cnt_clr)     cnt_m <= 0;
    else if (cnt_en) cnt_m <= (cnt_m == 120) ? 0 : cnt_m + 1;
  end

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: one sample per cycle, 1 ns after the falling edge.
  int  cyc = 0, en_tot = 0, clr_tot = 0, done_tot = 0, err_tot = 0;
  int  wraps_m = 0, last_wrap_cyc = 0, last_done_cyc = 0;
  bit  mon_on = 1'b0;
  always begin
    @(negedge Clk);
    #1;
    cyc++;
    en_tot   += int'(cnt_en);
    clr_tot  += int'(cnt_clr);
    done_tot += int'(done);
    err_tot  += int'(err);
    if (mon_on) begin
      if (cnt_clr && busy) wraps_m = 0;
      chk_eq("lap_track", int'(lap_cnt), wraps_m);
      chk_eq("clr_en_excl", int'(cnt_clr & cnt_en), 0);
      chk_eq("done_not_busy", int'(done & busy), 0);
    end
    if (cnt_en && tc && !stop) begin
      wraps_m++;
      last_wrap_cyc = cyc;
    end
    if (done) last_done_cyc = cyc;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic pulse_start(input int l);
    laps  = LAPW'(l);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 3000) begin
      tick(1);
      k++;
    end
    chk_eq({tag, "_timeout"}, int'(k < 3000), 1);
    tick(1);
  endtask

  task automatic wait_run_at(input int lap, input int v, input string tag);
    int k = 0;
    while (!(cnt_en && cnt_m == v && int'(lap_cnt) == lap) && k < 3000) begin
      tick(1);
      k++;
    end
    chk_eq({tag, "_timeout"}, int'(k < 3000), 1);
  endtask

  int en0, clr0, done0, err0;
  task automatic snap();
    en0 = en_tot; clr0 = clr_tot; done0 = done_tot; err0 = err_tot;
  endtask

  initial begin
    // Reset state
    tick(2);
    chk_eq("rst_cnt_en", int'(cnt_en), 0);
    chk_eq("rst_cnt_clr", int'(cnt_clr), 0);
    chk_eq("rst_busy", int'(busy), 0);
    chk_eq("rst_done", int'(done), 0);
    chk_eq("rst_err", int'(err), 0);
    chk_eq("rst_lap_cnt", int'(lap_cnt), 0);
    MR = 1'b1;
    tick(2);
    mon_on = 1'b1;

    // Two laps, no pauses
    snap();
    pulse_start(2);
    chk_eq("a_clear_busy", int'(busy), 1);
    chk_eq("a_clear_clr", int'(cnt_clr), 1);
    wait_idle("a");
    chk_eq("a_en_cycles", en_tot - en0, 242);
    chk_eq("a_clr_cycles", clr_tot - clr0, 1);
    chk_eq("a_done_pulses", done_tot - done0, 1);
    chk_eq("a_lap_cnt", int'(lap_cnt), 2);
    chk_eq("a_busy_after", int'(busy), 0);
    chk_eq("a_done_after_wrap", last_done_cyc - last_wrap_cyc, 1);

    // One lap with a 10-cycle pause freezing the counter at 50
    snap();
    pulse_start(1);
    wait_run_at(0, 49, "b");
    pause = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      chk_eq("b_hold_en", int'(cnt_en), 0);
      chk_eq("b_hold_cnt", cnt_m, 50);
      if (i == 10) pause = 1'b0;
    end
    tick(1);
    chk_eq("b_resume_en", int'(cnt_en), 1);
    wait_idle("b");
    chk_eq("b_en_cycles", en_tot - en0, 121);
    chk_eq("b_done_pulses", done_tot - done0, 1);
    chk_eq("b_lap_cnt", int'(lap_cnt), 1);

    // Three laps, stop at lap 1 count 30
    snap();
    pulse_start(3);
    wait_run_at(1, 30, "c");
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk_eq("c_stop_busy", int'(busy), 0);
    chk_eq("c_stop_clr", int'(cnt_clr), 1);
    chk_eq("c_stop_en", int'(cnt_en), 0);
    tick(1);
    chk_eq("c_clr_one_cycle", int'(cnt_clr), 0);
    chk_eq("c_cnt_cleared", cnt_m, 0);
    tick(3);
    chk_eq("c_no_done", done_tot - done0, 0);
    chk_eq("c_clr_cycles", clr_tot - clr0, 2);
    chk_eq("c_lap_cnt", int'(lap_cnt), 1);

    // laps=0 is rejected; stop overrides start
    snap();
    pulse_start(0);
    chk_eq("d_err", int'(err), 1);
    chk_eq("d_busy", int'(busy), 0);
    chk_eq("d_clr", int'(cnt_clr), 0);
    tick(1);
    chk_eq("d_err_pulse", int'(err), 0);
    laps = 8'd5; start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    chk_eq("d_stop_ovr_busy", int'(busy), 0);
    tick(1);
    chk_eq("d_err_count", err_tot - err0, 1);
    chk_eq("d_clr_count", clr_tot - clr0, 0);

    // Pause rising on the final wrap: DONE wins over HOLD
    snap();
    pulse_start(1);
    wait_run_at(0, 120, "e");
    pause = 1'b1;
    tick(1);
    chk_eq("e_done", int'(done), 1);
    chk_eq("e_lap_cnt", int'(lap_cnt), 1);
    chk_eq("e_en", int'(cnt_en), 0);
    chk_eq("e_busy", int'(busy), 0);
    pause = 1'b0;
    tick(2);
    chk_eq("e_done_pulses", done_tot - done0, 1);
    chk_eq("e_en_cycles", en_tot - en0, 121);

    // Asynchronous reset mid-run at count 77
    pulse_start(2);
    wait_run_at(0, 77, "f");
    mon_on = 1'b0;
    #2 MR = 1'b0;
    #1;
    chk_eq("f_async_en", int'(cnt_en), 0);
    chk_eq("f_async_busy", int'(busy), 0);
    chk_eq("f_async_clr", int'(cnt_clr), 0);
    chk_eq("f_async_done", int'(done), 0);
    chk_eq("f_async_err", int'(err), 0);
    chk_eq("f_async_lap", int'(lap_cnt), 0);
    MR = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk_eq("f_idle_busy", int'(busy), 0);
      chk_eq("f_idle_clr", int'(cnt_clr), 0);
    end
    chk_eq("f_cnt_kept", cnt_m, 77);
    // start held across a reset pulse takes effect only on a clock edge
    #2 MR = 1'b0;
    #1;
    laps = 8'd1; start = 1'b1; MR = 1'b1;
    #1;
    chk_eq("f_no_edge_busy", int'(busy), 0);
    tick(1);
    start = 1'b0;
    chk_eq("f_edge_busy", int'(busy), 1);
    chk_eq("f_edge_clr", int'(cnt_clr), 1);
    mon_on = 1'b1;
    snap();
    wait_idle("f");
    chk_eq("f_lap_cnt", int'(lap_cnt), 1);
    chk_eq("f_done_pulses", done_tot - done0, 1);

    // Randomized runs: pauses, ignored starts, laps changes, optional stop
    for (int r = 0; r < 10; r++) begin
      int  l;
      bit  do_stop, stopped;
      int  k;
      l       = int'($urandom_range(1, 3));
      do_stop = ($urandom_range(0, 2) == 0);
      stopped = 1'b0;
      k       = 0;
      snap();
      pulse_start(l);
      while (busy && k < 3000) begin
        if ($urandom_range(0, 15) == 0) pause = ~pause;
        start = ($urandom_range(0, 7) == 0);
        laps  = LAPW'($urandom);
        if (do_stop && !stopped && !cnt_clr && $urandom_range(0, 199) == 0) begin
          stop    = 1'b1;
          stopped = 1'b1;
        end else begin
          stop = 1'b0;
        end
        tick(1);
        k++;
      end
      stop = 1'b0; start = 1'b0; pause = 1'b0;
      chk_eq("r_timeout", int'(k < 3000), 1);
      tick(1);
      chk_eq("r_no_err", err_tot - err0, 0);
      if (stopped) begin
        chk_eq("r_stop_no_done", done_tot - done0, 0);
        chk_eq("r_stop_clr", clr_tot - clr0, 2);
      end else begin
        chk_eq("r_en_cycles", en_tot - en0, 121 * l);
        chk_eq("r_done_pulses", done_tot - done0, 1);
        chk_eq("r_clr_cycles", clr_tot - clr0, 1);
        chk_eq("r_lap_cnt", int'(lap_cnt), l);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
